bus_mem_responder: RTL and testbench

Memory-side target for the core bus arbiter's DRAM channel. It accepts the arbiter's registered load/store strobes, raises `w_dram_busy` for a fixed latency, then completes the access against an internal word-addressed RAM. It drives `w_dram_odata` with sized, sign- or zero-extended load data. It sits where the DRAM controller attaches and serves as a deterministic on-chip memory for single- and dual-core builds and benches.

---
 rtl/bus_mem_responder.sv | 216 +++++++++++++++++++++
 tb/tb_bus_mem_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// bus_mem_responder
//   Memory-side target for the core bus arbiter's DRAM channel. A load or
//   store strobe seen in IDLE is latched, busy is held for LATENCY cycles, and
//   the access then completes against an internal word-addressed RAM. Load
//   data is sized and sign/zero-extended according to the funct3 code.
//
// Ports
//   CLK           in   clock, rising edge
//   RST_X         in   asynchronous reset, active low
//   w_dram_addr   in   byte address; word index = addr[ADDR_WIDTH+1:2]
//   w_dram_wdata  in   store data, right-aligned
//   w_dram_ctrl   in   funct3 size/sign code
//   w_dram_le     in   load strobe
//   w_dram_we_t   in   store strobe
//   w_dram_odata  out  load result (holds until next completion)
//   w_dram_busy   out  access in progress
//   w_dram_err    out  last completed access was illegal
module bus_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic [2:0]  w_dram_ctrl,
  input  logic        w_dram_le,
  input  logic        w_dram_we_t,
  output logic [31:0] w_dram_odata,
  output logic        w_dram_busy,
  output logic        w_dram_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_ctrl;
  logic                  r_store;   // 1: store, 0: load
  logic                  r_both;    // both strobes were high at acceptance
  logic [7:0]            r_cnt;
  logic                  r_busy;
  logic [31:0]           r_odata;
  logic                  r_err;

  logic [31:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_done;
  logic                  w_illegal;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_widx;
  logic [31:0]           w_rd_word;
  logic [7:0]            w_rd_byte;
  logic [15:0]           w_rd_half;
  logic [31:0]           w_ld_data;
  logic [3:0]            w_be;
  logic [31:0]           w_wr_word;
  logic                  w_unused_addr;

  // Address bits above the RAM are don't-care; addresses simply wrap.
  assign w_unused_addr = ^w_dram_addr[31:ADDR_WIDTH+2];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dram_le | w_dram_we_t) begin
          w_state_nxt = BUSY;
          w_accept    = 1'b1;
        end
      end
      BUSY: begin
        // Strobes are ignored here; completion when the countdown hits zero.
        if (r_cnt == 8'd0) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, countdown and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_ctrl  <= '0;
      r_store <= 1'b0;
      r_both  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_odata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= w_dram_addr[ADDR_WIDTH+1:0];
        r_wdata <= w_dram_wdata;
        r_ctrl  <= w_dram_ctrl;
        // Simultaneous strobes are carried as a store so nothing reads stale
        // data, but r_both forces the error path so it never writes.
        r_store <= w_dram_we_t;
        r_both  <= w_dram_le & w_dram_we_t;
        r_cnt   <= 8'(LATENCY - 1);
        r_busy  <= 1'b1;
      end else if (r_state == BUSY && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end

      if (w_done) begin
        r_busy <= 1'b0;
        if (w_illegal) begin
          r_odata <= '0;
          r_err   <= 1'b1;
        end else begin
          r_err <= 1'b0;
          if (!r_store) r_odata <= w_ld_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Legality decode on the latched request
  // ---------------------------------------------------------------------------
  always_comb begin
    w_illegal = r_both;
    if (r_store) begin
      if (r_ctrl[2] || r_ctrl[1:0] == 2'b11) w_illegal = 1'b1;
    end else begin
      if (r_ctrl == 3'b011 || r_ctrl == 3'b110 || r_ctrl == 3'b111) w_illegal = 1'b1;
    end
    // Alignment: halves need addr[0]=0, words need addr[1:0]=00.
    if (r_ctrl[1:0] == 2'b01 && r_addr[0])          w_illegal = 1'b1;
    if (r_ctrl[1:0] == 2'b10 && r_addr[1:0] != 2'b00) w_illegal = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // RAM read path and load extraction
  // ---------------------------------------------------------------------------
  assign w_widx    = r_addr[ADDR_WIDTH+1:2];
  assign w_rd_word = r_mem[w_widx];

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_rd_byte = w_rd_word[7:0];
      2'd1:    w_rd_byte = w_rd_word[15:8];
      2'd2:    w_rd_byte = w_rd_word[23:16];
      default: w_rd_byte = w_rd_word[31:24];
    endcase
    w_rd_half = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    case (r_ctrl)
      3'b000:  w_ld_data = {{24{w_rd_byte[7]}}, w_rd_byte};
      3'b001:  w_ld_data = {{16{w_rd_half[15]}}, w_rd_half};
      3'b010:  w_ld_data = w_rd_word;
      3'b100:  w_ld_data = {24'd0, w_rd_byte};
      3'b101:  w_ld_data = {16'd0, w_rd_half};
      default: w_ld_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM write path: byte-lane enables with the store data replicated per lane
  // ---------------------------------------------------------------------------
  always_comb begin
    case (r_ctrl[1:0])
      2'b00: begin
        w_be      = 4'b0001 << r_addr[1:0];
        w_wr_word = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be      = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wr_word = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be      = 4'b1111;
        w_wr_word = r_wdata;
      end
    endcase
  end

  // Reset aborts via r_state, so an interrupted store never reaches here.
  assign w_wr_en = w_done & r_store & ~w_illegal;

  // RAM contents are deliberately left uninitialised by reset.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) r_mem[w_widx][l*8 +: 8] <= w_wr_word[l*8 +: 8];
      end
    end
  end

  assign w_dram_busy  = r_busy;
  assign w_dram_odata = r_odata;
  assign w_dram_err   = r_err;

endmodule

// File: tb/tb_bus_mem_responder.sv
module tb_bus_mem_responder;

  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic [31:0] w_dram_addr = '0;
  logic [31:0] w_dram_wdata = '0;
  logic [2:0]  w_dram_ctrl = '0;
  logic        w_dram_le = 1'b0;
  logic        w_dram_we_t = 1'b0;
  logic [31:0] w_dram_odata;
  logic        w_dram_busy;
  logic        w_dram_err;

  int n_checks = 0;
  int n_err    = 0;
  int nb;

  always #5 CLK = ~CLK;

  bus_mem_responder #(.ADDR_WIDTH(12), .LATENCY(LAT)) dut (
    .CLK          (CLK),
    .RST_X        (RST_X),
    .w_dram_addr  (w_dram_addr),
    .w_dram_wdata (w_dram_wdata),
    .w_dram_ctrl  (w_dram_ctrl),
    .w_dram_le    (w_dram_le),
    .w_dram_we_t  (w_dram_we_t),
    .w_dram_odata (w_dram_odata),
    .w_dram_busy  (w_dram_busy),
    .w_dram_err   (w_dram_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: strobe presented for a single edge, then busy cycles are
  // counted (bounded) until busy drops.
  task automatic access(input logic le, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] c, output int nbusy);
    @(negedge CLK);
    w_dram_le = le; w_dram_we_t = we;
    w_dram_addr = a; w_dram_wdata = d; w_dram_ctrl = c;
    @(posedge CLK); #1;
    w_dram_le = 1'b0; w_dram_we_t = 1'b0;
    nbusy = 0;
    while (w_dram_busy && nbusy < 20) begin
      nbusy++;
      @(posedge CLK); #1;
    end
  endtask

  // Access followed by checks of busy length, err and odata.
  task automatic op(input string tag, input logic le, input logic we,
                    input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                    input logic [31:0] exp_od, input logic exp_err);
    int n;
    access(le, we, a, d, c, n);
    chk({tag, ".busy"}, 32'(n), 32'(LAT));
    chk({tag, ".err"},  {31'd0, w_dram_err}, {31'd0, exp_err});
    chk({tag, ".odata"}, w_dram_odata, exp_od);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.busy",  {31'd0, w_dram_busy}, 32'd0);
    chk("rst.odata", w_dram_odata, 32'd0);
    chk("rst.err",   {31'd0, w_dram_err}, 32'd0);
    @(negedge CLK); RST_X = 1'b1;

    // Word round trip
    op("sw100", 0, 1, 32'h100, 32'h12345678, 3'b010, 32'h0, 0);
    op("lw100", 1, 0, 32'h100, 32'h0, 3'b010, 32'h12345678, 0);

    // Byte store and sized loads
    op("sb101",  0, 1, 32'h101, 32'h000000AA, 3'b000, 32'h12345678, 0);
    op("lb101",  1, 0, 32'h101, 32'h0, 3'b000, 32'hFFFFFFAA, 0);
    op("lbu101", 1, 0, 32'h101, 32'h0, 3'b100, 32'h000000AA, 0);
    op("lw100b", 1, 0, 32'h100, 32'h0, 3'b010, 32'h1234AA78, 0);

    // Half store and sized loads; word becomes 0x8001AA78
    op("sh102",  0, 1, 32'h102, 32'hFFFF8001, 3'b001, 32'h1234AA78, 0);
    op("lh102",  1, 0, 32'h102, 32'h0, 3'b001, 32'hFFFF8001, 0);
    op("lhu102", 1, 0, 32'h102, 32'h0, 3'b101, 32'h00008001, 0);

    // Misaligned accesses, then confirm no write happened
    op("lw102mis", 1, 0, 32'h102, 32'h0, 3'b010, 32'h0, 1);
    op("sh103mis", 0, 1, 32'h103, 32'h5555, 3'b001, 32'h0, 1);
    op("lw100c",   1, 0, 32'h100, 32'h0, 3'b010, 32'h8001AA78, 0);

    // Both strobes high: error, no write
    op("both",   1, 1, 32'h100, 32'h0, 3'b010, 32'h0, 1);
    op("lw100d", 1, 0, 32'h100, 32'h0, 3'b010, 32'h8001AA78, 0);

    // Illegal codes
    op("ld011", 1, 0, 32'h100, 32'h0, 3'b011, 32'h0, 1);
    op("st110", 0, 1, 32'h100, 32'h0, 3'b110, 32'h0, 1);
    op("lw100e", 1, 0, 32'h100, 32'h0, 3'b010, 32'h8001AA78, 0);

    // Address wrap: 0x4010 aliases word 4
    op("swalias", 0, 1, 32'h4010, 32'hCAFEF00D, 3'b010, 32'h8001AA78, 0);
    op("lw010",   1, 0, 32'h10, 32'h0, 3'b010, 32'hCAFEF00D, 0);
    op("sw010",   0, 1, 32'h10, 32'h0BADF00D, 3'b010, 32'hCAFEF00D, 0);
    op("lwalias", 1, 0, 32'h4010, 32'h0, 3'b010, 32'h0BADF00D, 0);

    // Reset in the second busy cycle of a store aborts it
    op("sw200", 0, 1, 32'h200, 32'h11112222, 3'b010, 32'h0BADF00D, 0);
    op("lw200", 1, 0, 32'h200, 32'h0, 3'b010, 32'h11112222, 0);
    @(negedge CLK);
    w_dram_we_t = 1'b1; w_dram_addr = 32'h200;
    w_dram_wdata = 32'hDEADBEEF; w_dram_ctrl = 3'b010;
    @(posedge CLK); #1;
    w_dram_we_t = 1'b0;
    chk("abort.busy1", {31'd0, w_dram_busy}, 32'd1);
    @(posedge CLK); #1;
    RST_X = 1'b0;
    #1;
    chk("abort.busy",  {31'd0, w_dram_busy}, 32'd0);
    chk("abort.odata", w_dram_odata, 32'd0);
    @(negedge CLK); @(negedge CLK);
    RST_X = 1'b1;
    op("lw200post", 1, 0, 32'h200, 32'h0, 3'b010, 32'h11112222, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
